// File: rtl/debug_rom_wb_if.sv
// Pipelined Wishbone slave front-end for the 64-bit debug ROM: turns 32-bit word reads into
// ROM line fetches, keeps one 64-bit line buffered so the sibling word hits, rejects writes.
module debug_rom_wb_if #(
  parameter int ROM_LINES = 20,
  parameter int ADR_W     = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic             wb_stall_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic [31:0]      wb_dat_o,
  output logic             rom_req_o,
  output logic [63:0]      rom_addr_o,
  input  logic [63:0]      rom_rdata_i,
  output logic [2:0]       dbg_state_o,
  output logic             dbg_oob_o
);

  // Handshake: a request is accepted on a rising edge where wb_cyc_i & wb_stb_i & !wb_stall_o;
  // exactly one of wb_ack_o / wb_err_o answers it for one cycle, unless the cycle is aborted.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_FILL  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  line_q, line_d;
  logic        half_q, half_d;
  logic        abort_q, abort_d;

  logic        buf_valid_q;
  logic [4:0]  buf_tag_q;
  logic [63:0] buf_data_q;

  logic        ack_q, err_q, rom_req_q;
  logic [31:0] dat_q, dat_d;
  logic [63:0] rom_addr_q, rom_addr_d;

  logic        accept;
  logic        hit;
  logic        fill_en;
  logic [63:0] resp_src;

  logic unused_inputs;
  assign unused_inputs = ^{wb_sel_i, wb_dat_i, wb_adr_i[ADR_W-1:6]};

  assign accept  = wb_cyc_i & wb_stb_i & (state_q == S_IDLE);
  assign hit     = buf_valid_q && (buf_tag_q == wb_adr_i[5:1]);
  assign fill_en = (state_q == S_FILL);

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    half_d  = half_q;
    abort_d = abort_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (wb_we_i) begin
            state_d = S_ERR;
          end else begin
            line_d  = wb_adr_i[5:1];
            half_d  = wb_adr_i[0];
            state_d = hit ? S_RESP : S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        state_d = S_FILL;
      end
      S_FILL: begin
        // The line is still captured on abort; only the response is dropped.
        state_d = (abort_q || !wb_cyc_i) ? S_IDLE : S_RESP;
        abort_d = 1'b0;
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // On a miss the data bypasses the buffer, which is written on the same edge.
  always_comb begin
    resp_src   = fill_en ? rom_rdata_i : buf_data_q;
    dat_d      = 32'h0;
    rom_addr_d = rom_addr_q;
    if (state_d == S_RESP) dat_d = half_d ? resp_src[63:32] : resp_src[31:0];
    if (state_d == S_FETCH) rom_addr_d = {56'h0, line_d, 3'b000};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      line_q      <= 5'h0;
      half_q      <= 1'b0;
      abort_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= 5'h0;
      buf_data_q  <= 64'h0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rom_req_q   <= 1'b0;
      dat_q       <= 32'h0;
      rom_addr_q  <= 64'h0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      half_q     <= half_d;
      abort_q    <= abort_d;
      ack_q      <= (state_d == S_RESP);
      err_q      <= (state_d == S_ERR);
      rom_req_q  <= (state_d == S_FETCH);
      dat_q      <= dat_d;
      rom_addr_q <= rom_addr_d;
      if (fill_en) begin
        buf_valid_q <= 1'b1;
        buf_tag_q   <= line_q;
        buf_data_q  <= rom_rdata_i;
      end
    end
  end

  assign wb_stall_o  = (state_q != S_IDLE);
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_dat_o    = dat_q;
  assign rom_req_o   = rom_req_q;
  assign rom_addr_o  = rom_addr_q;
  assign dbg_state_o = state_q;
  assign dbg_oob_o   = int'({27'h0, line_q}) >= ROM_LINES;

endmodule
